// File: rtl/fx_requant_pipe_if.sv
// Stream, configuration and statistics bundle for fx_requant_pipe.
// slave is the requantiser's view, master is the producer/consumer view.
interface fx_requant_pipe_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 7,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 16
);
  logic [1:0]           cfg_rnd;
  logic                 cfg_sat;
  logic                 clr_stats;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*IN_W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*OUT_W-1:0] out_data;
  logic [NCH-1:0]       out_sat;
  logic [NCH*CNT_W-1:0] sat_cnt;

  modport slave (
    input  cfg_rnd, cfg_sat, clr_stats, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, sat_cnt
  );

  modport master (
    output cfg_rnd, cfg_sat, clr_stats, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, sat_cnt
  );
endinterface

// File: rtl/fx_requant_pipe.sv
// Two-stage multi-channel fixed-point requantiser: S1 aligns and rounds,
// S2 checks overflow, saturates or wraps, and registers the outputs.
module fx_requant_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned IN_I   = 1,
  parameter int unsigned OUT_W  = 7,
  parameter int unsigned OUT_I  = 1,
  parameter int unsigned NCH    = 2,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  fx_requant_pipe_if.slave bus
);

  localparam int          IN_FRAC  = int'(IN_W) - int'(IN_I);
  localparam int          OUT_FRAC = int'(OUT_W) - int'(OUT_I);
  localparam int          SH       = IN_FRAC - OUT_FRAC;
  localparam int unsigned ASH      = (SH > 0) ? $unsigned(SH) : $unsigned(-SH);
  localparam int unsigned MW_RAW   = IN_W + ASH + 1;
  // Keep at least two bits above OUT_W so the range compare never aliases.
  localparam int unsigned MW       = (MW_RAW > OUT_W + 2) ? MW_RAW : OUT_W + 2;

  localparam logic signed [MW-1:0] MAXV = (SIGNED != 0) ?
      MW'((longint'(1) << (OUT_W - 1)) - 1) : MW'((longint'(1) << OUT_W) - 1);
  localparam logic signed [MW-1:0] MINV = (SIGNED != 0) ?
      MW'(-(longint'(1) << (OUT_W - 1))) : '0;

  logic                 adv;
  logic                 s1_valid;
  logic                 s1_sat;
  logic [NCH*MW-1:0]    s1_v;
  logic [NCH*MW-1:0]    v1_c;
  logic [NCH*OUT_W-1:0] res_c;
  logic [NCH-1:0]       ovf_c;
  logic                 out_valid_q;
  logic [NCH*OUT_W-1:0] out_data_q;
  logic [NCH-1:0]       out_sat_q;
  logic [NCH*CNT_W-1:0] cnt_q;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = rst_n & adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_cnt   = cnt_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [IN_W-1:0]      x_raw;
    logic                 ext_bit;
    logic signed [MW-1:0] x_ext;
    logic signed [MW-1:0] v_c;
    logic signed [MW-1:0] v2;
    logic                 hi;
    logic                 lo;

    assign x_raw   = bus.in_data[k*IN_W +: IN_W];
    assign ext_bit = (SIGNED != 0) & x_raw[IN_W-1];
    assign x_ext   = {{(MW-IN_W){ext_bit}}, x_raw};

    if (SH > 0) begin : g_rnd
      // Arithmetic shift gives floor; the dropped bits are the remainder.
      localparam logic [ASH-1:0] HALF = ASH'(1) << (ASH - 1);
      logic signed [MW-1:0] q;
      logic [ASH-1:0]       r;
      logic                 inc;

      assign q = x_ext >>> ASH;
      assign r = x_ext[ASH-1:0];

      always_comb begin
        inc = 1'b0;
        case (bus.cfg_rnd)
          2'b01:   inc = (r >= HALF);
          2'b10:   inc = (r > HALF) || ((r == HALF) && q[0]);
          default: inc = 1'b0;
        endcase
      end

      assign v_c = q + MW'(inc);
    end else begin : g_shl
      assign v_c = x_ext <<< ASH;
    end

    assign v1_c[k*MW +: MW] = v_c;

    assign v2    = s1_v[k*MW +: MW];
    assign hi    = (v2 > MAXV);
    assign lo    = (v2 < MINV);
    assign ovf_c[k] = hi | lo;
    assign res_c[k*OUT_W +: OUT_W] = (s1_sat && hi) ? MAXV[OUT_W-1:0] :
                                     (s1_sat && lo) ? MINV[OUT_W-1:0] :
                                                      v2[OUT_W-1:0];
  end

  // Pipeline registers; the whole pipe shifts together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sat      <= 1'b0;
      s1_v        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      if (bus.in_valid) begin
        s1_v   <= v1_c;
        s1_sat <= bus.cfg_sat;
      end
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_data_q <= res_c;
        out_sat_q  <= ovf_c;
      end
    end
  end

  // Sticky per-channel overflow counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_stats) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (out_sat_q[k] && (cnt_q[k*CNT_W +: CNT_W] != '1)) begin
          cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fx_requant_pipe.sv
// Scoreboarded bench for fx_requant_pipe: a 16-bit-counter DUT and a
// 2-bit-counter DUT share all stimulus and are checked against one model.
module tb_fx_requant_pipe;

  typedef struct packed {
    logic [13:0] data;
    logic [1:0]  sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fx_requant_pipe_if #(.IN_W(16), .OUT_W(7), .NCH(2), .CNT_W(16)) bus ();
  fx_requant_pipe_if #(.IN_W(16), .OUT_W(7), .NCH(2), .CNT_W(2))  bus2 ();

  assign bus2.cfg_rnd   = bus.cfg_rnd;
  assign bus2.cfg_sat   = bus.cfg_sat;
  assign bus2.clr_stats = bus.clr_stats;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  fx_requant_pipe #(.CNT_W(16)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  fx_requant_pipe #(.CNT_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  exp_t        sb[$];
  int          c16[2];
  int          c2[2];
  logic [13:0] last_data = '0;
  logic [1:0]  last_sat  = '0;

  // Reference: 16/1 -> 7/1 signed, using integer floor division.
  function automatic logic [7:0] req(input logic [15:0] x, input logic [1:0] rnd,
                                     input logic sat);
    int xi, r, q, v;
    logic ovf;
    logic [6:0] o;
    xi = int'($signed(x));
    r  = ((xi % 512) + 512) % 512;
    q  = (xi - r) / 512;
    case (rnd)
      2'b01:   v = q + ((r >= 256) ? 1 : 0);
      2'b10:   v = q + (((r > 256) || (r == 256 && (q % 2 != 0))) ? 1 : 0);
      default: v = q;
    endcase
    ovf = (v > 63) || (v < -64);
    if (sat && v > 63)       o = 7'h3F;
    else if (sat && v < -64) o = 7'h40;
    else                     o = 7'(v);
    return {ovf, o};
  endfunction

  function automatic exp_t model(input logic [31:0] d, input logic [1:0] rnd,
                                 input logic sat);
    exp_t e;
    logic [7:0] a, b;
    a = req(d[15:0], rnd, sat);
    b = req(d[31:16], rnd, sat);
    e.data = {b[6:0], a[6:0]};
    e.sat  = {b[7], a[7]};
    return e;
  endfunction

  // Scoreboard: at each negedge, check counters, pop on output handshake,
  // push on input handshake (both handshakes complete at the next posedge).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      n_checks++;
      if (bus.sat_cnt !== {16'(c16[1]), 16'(c16[0])}) begin
        n_fail++;
        $display("FAIL sat_cnt16: got %h want %h", bus.sat_cnt, {16'(c16[1]), 16'(c16[0])});
      end
      n_checks++;
      if (bus2.sat_cnt !== {2'(c2[1]), 2'(c2[0])}) begin
        n_fail++;
        $display("FAIL sat_cnt2: got %h want %h", bus2.sat_cnt, {2'(c2[1]), 2'(c2[0])});
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got data %h with empty scoreboard", bus.out_data);
        end else begin
          e = sb.pop_front();
          n_out++;
          if (bus.out_data !== e.data || bus.out_sat !== e.sat) begin
            n_fail++;
            $display("FAIL sb_output: got %h/%b want %h/%b", bus.out_data, bus.out_sat, e.data, e.sat);
          end
          n_checks++;
          if (bus2.out_data !== e.data || bus2.out_sat !== e.sat) begin
            n_fail++;
            $display("FAIL sb_output2: got %h/%b want %h/%b", bus2.out_data, bus2.out_sat, e.data, e.sat);
          end
          last_data = bus.out_data;
          last_sat  = bus.out_sat;
          for (int k = 0; k < 2; k++) begin
            if (e.sat[k]) begin
              if (c16[k] < 65535) c16[k]++;
              if (c2[k] < 3)      c2[k]++;
            end
          end
        end
      end
      if (bus.clr_stats) begin
        c16 = '{0, 0};
        c2  = '{0, 0};
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_data, bus.cfg_rnd, bus.cfg_sat));
    end
  end

  task automatic wait_drain();
    int b = 0;
    while (sb.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic one(input logic [31:0] d, input logic [1:0] rnd, input logic sat);
    bus.cfg_rnd  = rnd;
    bus.cfg_sat  = sat;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic drive(input logic [31:0] d);
    int b = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout: got in_ready %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sat !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%h/%b want 0/0/0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    n_checks++;
    if (bus.sat_cnt !== '0 || bus2.sat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h/%h want 0/0", bus.sat_cnt, bus2.sat_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_default();
    bus.cfg_rnd  = 2'b00;
    bus.cfg_sat  = 1'b1;
    bus.in_data  = {16'h2100, 16'h3FFF};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got out_valid %b want 0", bus.out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {7'h10, 7'h1F} || bus.out_sat !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_trunc: got %b/%h/%b want 1/%h/00", bus.out_valid, bus.out_data,
               bus.out_sat, {7'h10, 7'h1F});
    end
    wait_drain();
    one({16'h2100, 16'h3FFF}, 2'b01, 1'b1);
    n_checks++;
    if (last_data !== {7'h11, 7'h20}) begin
      n_fail++;
      $display("FAIL half_up_3fff: got %h want %h", last_data, {7'h11, 7'h20});
    end
  endtask

  task automatic test_overflow();
    bus.clr_stats = 1'b1;
    @(posedge clk); #1;
    bus.clr_stats = 1'b0;
    one({16'h7FFF, 16'h7FFF}, 2'b01, 1'b1);
    n_checks++;
    if (last_data !== {7'h3F, 7'h3F} || last_sat !== 2'b11 || bus.sat_cnt !== {16'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL ovf_sat: got %h/%b/%h want %h/11/%h", last_data, last_sat, bus.sat_cnt,
               {7'h3F, 7'h3F}, {16'd1, 16'd1});
    end
    one({16'h7FFF, 16'h7FFF}, 2'b01, 1'b0);
    n_checks++;
    if (last_data !== {7'h40, 7'h40} || last_sat !== 2'b11 || bus.sat_cnt !== {16'd2, 16'd2}) begin
      n_fail++;
      $display("FAIL ovf_wrap: got %h/%b/%h want %h/11/%h", last_data, last_sat, bus.sat_cnt,
               {7'h40, 7'h40}, {16'd2, 16'd2});
    end
    one({16'h8000, 16'h8000}, 2'b01, 1'b1);
    n_checks++;
    if (last_data !== {7'h40, 7'h40} || last_sat !== 2'b00 || bus.sat_cnt !== {16'd2, 16'd2}) begin
      n_fail++;
      $display("FAIL min_exact: got %h/%b/%h want %h/00/%h", last_data, last_sat, bus.sat_cnt,
               {7'h40, 7'h40}, {16'd2, 16'd2});
    end
  endtask

  task automatic test_ties();
    logic [13:0] want[3];
    want[0] = {7'h6F, 7'h10};
    want[1] = {7'h70, 7'h11};
    want[2] = {7'h70, 7'h10};
    for (int m = 0; m < 3; m++) begin
      one({16'hDF00, 16'h2100}, 2'(m), 1'b1);
      n_checks++;
      if (last_data !== want[m] || last_sat !== 2'b00) begin
        n_fail++;
        $display("FAIL tie_mode%0d: got %h/%b want %h/00", m, last_data, last_sat, want[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [31:0] d[5];
    n0 = n_out;
    for (int i = 0; i < 5; i++)
      d[i] = {16'(16'hDF00 - 16'(i) * 16'h0200), 16'(16'h2100 + 16'(i) * 16'h0200)};
    bus.cfg_sat = 1'b1;
    bus.cfg_rnd = 2'b00;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          if (i == 2) bus.cfg_rnd = 2'b01;
          drive(d[i]);
        end
      end
      begin
        for (int c = 1; c <= 8; c++) begin
          bus.out_ready = !(c >= 3 && c <= 5);
          @(negedge clk);
          if (c == 4) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
              n_fail++;
              $display("FAIL stall_ready: got in_ready %b out_valid %b want 0 1",
                       bus.in_ready, bus.out_valid);
            end
          end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    n_checks++;
    if (n_out - n0 != 5) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want 5", n_out - n0);
    end
    n_checks++;
    if (last_data !== {7'h6C, 7'h15}) begin
      n_fail++;
      $display("FAIL stream_last: got %h want %h", last_data, {7'h6C, 7'h15});
    end
  endtask

  task automatic test_counter();
    int b = 0;
    bus.clr_stats = 1'b1;
    @(posedge clk); #1;
    bus.clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) one({16'h7FFF, 16'h7FFF}, 2'b01, 1'b1);
    n_checks++;
    if (bus2.sat_cnt !== 4'hF || bus.sat_cnt !== {16'd5, 16'd5}) begin
      n_fail++;
      $display("FAIL cnt_stick: got %h/%h want f/%h", bus2.sat_cnt, bus.sat_cnt, {16'd5, 16'd5});
    end
    bus.out_ready = 1'b0;
    bus.in_data   = {16'h7FFF, 16'h7FFF};
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && b < 10) begin
      @(posedge clk); #1;
      b++;
    end
    bus.out_ready = 1'b1;
    bus.clr_stats = 1'b1;
    @(posedge clk); #1;
    bus.clr_stats = 1'b0;
    n_checks++;
    if (last_sat !== 2'b11 || bus.sat_cnt !== '0 || bus2.sat_cnt !== '0) begin
      n_fail++;
      $display("FAIL clr_priority: got %b/%h/%h want 11/0/0", last_sat, bus.sat_cnt, bus2.sat_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b1;
    bus.cfg_sat   = 1'b1;
    bus.cfg_rnd   = 2'b01;
    bus.in_data   = {16'h7FFF, 16'h7FFF};
    bus.in_valid  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.sat_cnt !== {16'd1, 16'd1} || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got %h/%b want %h/1", bus.sat_cnt, bus.out_valid, {16'd1, 16'd1});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.sat_cnt !== '0 || bus2.sat_cnt !== '0 ||
        bus.out_data !== '0 || bus.out_sat !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b/%h/%h/%h want 0/0/0/0", bus.out_valid, bus.sat_cnt,
               bus2.sat_cnt, bus.out_data);
    end
    sb.delete();
    c16 = '{0, 0};
    c2  = '{0, 0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_after_reset: got out_valid %b want 0 (cycle %0d)", bus.out_valid, i);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    c16 = '{0, 0};
    c2  = '{0, 0};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_rnd   = 2'b00;
    bus.cfg_sat   = 1'b1;
    bus.clr_stats = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_default();
    test_overflow();
    test_ties();
    test_back_to_back();
    test_counter();
    test_reset_midflight();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fx_requant_pipe.md
Name: fx_requant_pipe

Overview:
- Parametrised, multi-channel fixed-point requantiser with a valid/ready handshake.
- Converts sc_fixed<IN_W,IN_I> samples to sc_fixed<OUT_W,OUT_I>, with selectable rounding and overflow modes, plus per-channel saturation statistics.
- Replaces the hard-coded width casts between DICD stages, for example in_r_t to r_t (16/1 to 7/1) and the internal casts to gamma/phi/lambda (14/6).
- Sits between any producer and consumer stage.

Parameters:
- IN_W, 16, input word width.
- IN_I, 1, input integer bits including sign; IN_FRAC = IN_W - IN_I.
- OUT_W, 7, output word width.
- OUT_I, 1, output integer bits; OUT_FRAC = OUT_W - OUT_I.
- NCH, 2, number of parallel channels (I/Q = 2).
- SIGNED, 1, 1 selects two's-complement (sc_fixed); 0 selects unsigned (sc_ufixed).
- CNT_W, 16, width of each saturation counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cfg_rnd  in  2  rounding mode: 00 truncate (floor), 01 round-half-up, 10 round-half-even, 11 behaves as 00.
- cfg_sat  in  1  overflow mode: 1 saturate, 0 wrap.
- clr_stats  in  1  synchronous clear of all sat_cnt.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input.
- in_data  in  NCH*IN_W  packed samples; channel k occupies bits [k*IN_W +: IN_W].
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts the output.
- out_data  out  NCH*OUT_W  packed requantised samples.
- out_sat  out  NCH  per-channel overflow flag, aligned with out_data.
- sat_cnt  out  NCH*CNT_W  per-channel overflow event counters.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_sat=0, sat_cnt=0, all internal valids 0. in_ready=1 once rst_n is high.
- Pipeline: two stages.
  - S1 aligns and rounds.
  - S2 performs the overflow check and registers the outputs.
  - Latency is 2 cycles from input handshake to out_valid.
  - Throughput is 1 sample per cycle.
- Stall rule: adv = !out_valid || out_ready. in_ready = adv, so in_ready depends combinationally on out_ready.
  - When adv=1, the whole pipe shifts: S1 captures the input when in_valid, and S2 captures S1.
  - When adv=0, all pipeline registers hold. No sample is lost or duplicated, and order is preserved.
- Configuration is sampled with each sample at S1 capture and travels with it. A cfg change affects only samples accepted after the change.
- Alignment: SH = IN_FRAC - OUT_FRAC (elaboration constant).
  - SH > 0: right shift by SH with rounding.
  - SH <= 0: exact left shift by -SH; rounding is a no-op.
  - The intermediate width is IN_W + |SH| + 1, so the rounding increment can never overflow internally.
- Rounding, with q = floor(x / 2^SH) and remainder r:
  - Truncate: q.
  - Half-up: floor(x / 2^SH + 0.5).
  - Half-even: q + (r > half, or r == half and q odd).
  - Signed negatives follow the same floor definition; -16.5 LSB half-up gives -16.
- Overflow check, on the rounded value v against the OUT_W range:
  - Signed range: [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Unsigned range: [0, 2^OUT_W - 1].
  - Out of range with cfg_sat=1: clamp to the nearest bound.
  - Out of range with cfg_sat=0: keep the low OUT_W bits.
  - out_sat[k]=1 whenever the value was out of range, in either mode.
- sat_cnt[k]:
  - Increments by 1 on each output handshake (out_valid && out_ready) where out_sat[k]=1.
  - Sticks at all-ones and never wraps.
  - clr_stats has priority: if it coincides with an increment, the result is 0.
- Idle: with in_valid=0 the pipe drains. out_data holds its last value when out_valid=0.
- Reset mid-operation: in-flight samples are discarded, outputs return to reset values, and no handshake completes on the reset cycle.

Test Plan:
- Defaults (16/1 to 7/1, SH=9), in 0x3FFF:
  - cfg_rnd=00 gives 0x1F.
  - cfg_rnd=01 gives 0x20.
  - out_valid rises exactly 2 cycles after the input handshake; out_sat=0.
- Overflow, in 0x7FFF with cfg_rnd=01:
  - cfg_sat=1 gives 0x3F, out_sat=1, sat_cnt=1.
  - cfg_sat=0 gives 0x40, out_sat=1, sat_cnt=2.
  - in 0x8000 gives 0x40 exact, out_sat=0.
- Tie cases, in 0x2100 (+16.5 LSB):
  - Truncate gives 0x10, half-up gives 0x11, half-even gives 0x10.
  - in 0xDF00 (-16.5 LSB): truncate gives 0x6F, half-up gives 0x70, half-even gives 0x70.
- Backpressure: stream 5 distinct samples with out_ready low on cycles 3-5.
  - in_ready drops while the pipe is full.
  - All 5 outputs appear in order with no duplicates.
  - A cfg_rnd change mid-stream applies only to samples accepted after the change.
- Counter: with CNT_W=2, force 5 saturating outputs.
  - sat_cnt sticks at 3.
  - clr_stats asserted in the same cycle as a saturating handshake gives 0.
- Reset: assert rst_n low with 2 samples in flight.
  - out_valid=0 and sat_cnt=0 immediately (asynchronously).
  - No stale sample appears after rst_n is released.
